// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared types and defaults for the ALU reservation station.
//   DEPTH_DEF / TAG_W_DEF : default entry count and ROB tag width.
//   TAG_W_MAX             : storage width of tags inside an entry. Narrower
//                           tags are zero-extended, so TAG_W must be at most 8.
//   opnd_t / entry_t      : one source operand and one queued instruction.
//   wake_opnd             : applies a CDB broadcast to a single operand.
package alu_rs_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned TAG_W_DEF = 4;
  localparam int unsigned TAG_W_MAX = 8;

  typedef logic [TAG_W_MAX-1:0] tag_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] value;
    tag_t        tag;
  } opnd_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    tag_t        tag;
    opnd_t       rs1;
    opnd_t       rs2;
  } entry_t;

  // A waiting operand whose producer tag matches the broadcast captures the
  // value and becomes ready. Operands that are already ready are never touched.
  function automatic opnd_t wake_opnd(opnd_t o, logic cdb_valid, tag_t cdb_tag,
                                      logic [31:0] cdb_value);
    opnd_t r;
    r = o;
    if (cdb_valid && !o.ready && (o.tag == cdb_tag)) begin
      r.ready = 1'b1;
      r.value = cdb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// alu_rs_select: lowest-index priority picker.
//   req   : per-slot request (slot 0 has the highest priority, it is oldest).
//   grant : one-hot grant of the lowest-index request, all zero if none.
//   found : at least one request was present.
module alu_rs_select #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station feeding the single-cycle arith unit.
// Buffers up to DEPTH instructions in a compacting age queue (slot 0 oldest),
// captures missing operands from the CDB, and issues the oldest fully ready
// entry each cycle through registered alu_* outputs.
//   clk_i, reset_i (async, active high), flush_i (synchronous squash)
//   dispatch_*   : valid/ready dispatch of pc, inst, dest tag and two operands
//   cdb_*        : result broadcast used for wakeup and dispatch bypass
//   alu_*        : registered issue request and payload
//   count_o      : number of occupied entries
// Build option: ALU_RS_WAKEUP_BYPASS_EN lets select see same-cycle CDB matches
// and forward cdb_value_i into the issued operand.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         dispatch_valid_i,
  output logic                         dispatch_ready_o,
  input  logic [31:0]                  dispatch_pc_i,
  input  logic [31:0]                  dispatch_inst_i,
  input  logic [TAG_W-1:0]             dispatch_tag_i,
  input  logic                         dispatch_rs1_ready_i,
  input  logic                         dispatch_rs2_ready_i,
  input  logic [31:0]                  dispatch_rs1_value_i,
  input  logic [31:0]                  dispatch_rs2_value_i,
  input  logic [TAG_W-1:0]             dispatch_rs1_tag_i,
  input  logic [TAG_W-1:0]             dispatch_rs2_tag_i,
  input  logic                         cdb_valid_i,
  input  logic [TAG_W-1:0]             cdb_tag_i,
  input  logic [31:0]                  cdb_value_i,
  input  logic                         flush_i,
  output logic                         alu_request_o,
  output logic [31:0]                  alu_pc_o,
  output logic [31:0]                  alu_inst_o,
  output logic [31:0]                  alu_rs1_value_o,
  output logic [31:0]                  alu_rs2_value_o,
  output logic [TAG_W-1:0]             alu_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  entry_t           entries    [DEPTH];
  entry_t           woke       [DEPTH];
  entry_t           entries_nx [DEPTH];
  entry_t           disp_e;
  opnd_t            disp_rs1_raw;
  opnd_t            disp_rs2_raw;
  tag_t             cdb_tag;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nx;
  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] grant;
  logic             found;
  logic             do_disp;
  logic             seen;
  logic [31:0]      wr_slot;
  logic [31:0]      sel_pc;
  logic [31:0]      sel_inst;
  logic [31:0]      sel_rs1;
  logic [31:0]      sel_rs2;
  logic [TAG_W-1:0] sel_tag;

  assign cdb_tag          = tag_t'(cdb_tag_i);
  assign dispatch_ready_o = (32'(count) < DEPTH);
  assign do_disp          = dispatch_valid_i && dispatch_ready_o;
  assign count_o          = count;

  assign disp_rs1_raw = '{ready: dispatch_rs1_ready_i, value: dispatch_rs1_value_i,
                          tag: tag_t'(dispatch_rs1_tag_i)};
  assign disp_rs2_raw = '{ready: dispatch_rs2_ready_i, value: dispatch_rs2_value_i,
                          tag: tag_t'(dispatch_rs2_tag_i)};

  // woke[] is every entry with this cycle's broadcast applied. It is the
  // state written back, and with bypass it is also what select looks at.
  always_comb begin
    rdy_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i]     = entries[i];
      woke[i].rs1 = wake_opnd(entries[i].rs1, cdb_valid_i, cdb_tag, cdb_value_i);
      woke[i].rs2 = wake_opnd(entries[i].rs2, cdb_valid_i, cdb_tag, cdb_value_i);
      if (BYPASS) begin
        rdy_vec[i] = (i < 32'(count)) && woke[i].rs1.ready && woke[i].rs2.ready;
      end else begin
        rdy_vec[i] = (i < 32'(count)) && entries[i].rs1.ready && entries[i].rs2.ready;
      end
    end
  end

  alu_rs_select #(.N(DEPTH)) u_select (
    .req   (rdy_vec),
    .grant (grant),
    .found (found)
  );

  // Payload is taken from woke[]. Without bypass the selected entry is
  // already ready, so its values equal the registered ones.
  always_comb begin
    sel_pc   = '0;
    sel_inst = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_pc   = woke[i].pc;
        sel_inst = woke[i].inst;
        sel_rs1  = woke[i].rs1.value;
        sel_rs2  = woke[i].rs2.value;
        sel_tag  = woke[i].tag[TAG_W-1:0];
      end
    end
  end

  // Compaction: every slot at or above the granted one takes its upper
  // neighbour. The top slot is left stale because it is invalid afterwards
  // unless the dispatch write below lands there.
  always_comb begin
    disp_e.pc   = dispatch_pc_i;
    disp_e.inst = dispatch_inst_i;
    disp_e.tag  = tag_t'(dispatch_tag_i);
    disp_e.rs1  = wake_opnd(disp_rs1_raw, cdb_valid_i, cdb_tag, cdb_value_i);
    disp_e.rs2  = wake_opnd(disp_rs2_raw, cdb_valid_i, cdb_tag, cdb_value_i);

    seen = 1'b0;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      seen          = seen | grant[i];
      entries_nx[i] = seen ? woke[i+1] : woke[i];
    end
    entries_nx[DEPTH-1] = woke[DEPTH-1];

    wr_slot = 32'(count) - 32'(found);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (do_disp && (i == wr_slot)) begin
        entries_nx[i] = disp_e;
      end
    end

    count_nx = count + CW'(do_disp) - CW'(found);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      entries         <= '{default: '0};
      count           <= '0;
      alu_request_o   <= 1'b0;
      alu_pc_o        <= '0;
      alu_inst_o      <= '0;
      alu_rs1_value_o <= '0;
      alu_rs2_value_o <= '0;
      alu_tag_o       <= '0;
    end else if (flush_i) begin
      count         <= '0;
      alu_request_o <= 1'b0;
    end else begin
      entries       <= entries_nx;
      count         <= count_nx;
      alu_request_o <= found;
      if (found) begin
        alu_pc_o        <= sel_pc;
        alu_inst_o      <= sel_inst;
        alu_rs1_value_o <= sel_rs1;
        alu_rs2_value_o <= sel_rs2;
        alu_tag_o       <= sel_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs. A directed table covers latency,
// wakeup, full/ordering, dispatch bypass and flush; a hand sequence covers
// asynchronous reset; a random phase is compared against a queue model.
module tb_alu_rs;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             reset_i;
  logic             dispatch_valid_i;
  logic             dispatch_ready_o;
  logic [31:0]      dispatch_pc_i;
  logic [31:0]      dispatch_inst_i;
  logic [TAG_W-1:0] dispatch_tag_i;
  logic             dispatch_rs1_ready_i;
  logic             dispatch_rs2_ready_i;
  logic [31:0]      dispatch_rs1_value_i;
  logic [31:0]      dispatch_rs2_value_i;
  logic [TAG_W-1:0] dispatch_rs1_tag_i;
  logic [TAG_W-1:0] dispatch_rs2_tag_i;
  logic             cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [31:0]      cdb_value_i;
  logic             flush_i;
  logic             alu_request_o;
  logic [31:0]      alu_pc_o;
  logic [31:0]      alu_inst_o;
  logic [31:0]      alu_rs1_value_o;
  logic [31:0]      alu_rs2_value_o;
  logic [TAG_W-1:0] alu_tag_o;
  logic [CW-1:0]    count_o;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .dispatch_valid_i     (dispatch_valid_i),
    .dispatch_ready_o     (dispatch_ready_o),
    .dispatch_pc_i        (dispatch_pc_i),
    .dispatch_inst_i      (dispatch_inst_i),
    .dispatch_tag_i       (dispatch_tag_i),
    .dispatch_rs1_ready_i (dispatch_rs1_ready_i),
    .dispatch_rs2_ready_i (dispatch_rs2_ready_i),
    .dispatch_rs1_value_i (dispatch_rs1_value_i),
    .dispatch_rs2_value_i (dispatch_rs2_value_i),
    .dispatch_rs1_tag_i   (dispatch_rs1_tag_i),
    .dispatch_rs2_tag_i   (dispatch_rs2_tag_i),
    .cdb_valid_i          (cdb_valid_i),
    .cdb_tag_i            (cdb_tag_i),
    .cdb_value_i          (cdb_value_i),
    .flush_i              (flush_i),
    .alu_request_o        (alu_request_o),
    .alu_pc_o             (alu_pc_o),
    .alu_inst_o           (alu_inst_o),
    .alu_rs1_value_o      (alu_rs1_value_o),
    .alu_rs2_value_o      (alu_rs2_value_o),
    .alu_tag_o            (alu_tag_o),
    .count_o              (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [TAG_W-1:0] t);
    return 32'h0000_1000 + (32'(t) << 2);
  endfunction

  function automatic logic [31:0] inst_of(input logic [TAG_W-1:0] t);
    return 32'h0000_0013 | (32'(t) << 7);
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit               dv;
    logic [TAG_W-1:0] tag;
    bit               r1r;
    logic [31:0]      r1v;
    logic [TAG_W-1:0] r1t;
    bit               r2r;
    logic [31:0]      r2v;
    logic [TAG_W-1:0] r2t;
    bit               cv;
    logic [TAG_W-1:0] ct;
    logic [31:0]      cval;
    bit               fl;
    bit               e_dr;
    int               e_cnt;
    bit               e_req;
    logic [TAG_W-1:0] e_tag;
    logic [31:0]      e1;
    logic [31:0]      e2;
  } vec_t;

  function automatic vec_t row(input int dv, tag, r1r, r1v, r1t, r2r, r2v, r2t,
                               cv, ct, cval, fl, e_dr, e_cnt, e_req, e_tag, e1, e2);
    vec_t v;
    v.dv = dv[0]; v.tag = TAG_W'(tag);
    v.r1r = r1r[0]; v.r1v = r1v; v.r1t = TAG_W'(r1t);
    v.r2r = r2r[0]; v.r2v = r2v; v.r2t = TAG_W'(r2t);
    v.cv = cv[0]; v.ct = TAG_W'(ct); v.cval = cval; v.fl = fl[0];
    v.e_dr = e_dr[0]; v.e_cnt = e_cnt; v.e_req = e_req[0];
    v.e_tag = TAG_W'(e_tag); v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  function automatic vec_t idle(input int e_dr, e_cnt, e_req, e_tag, e1, e2);
    return row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_dr, e_cnt, e_req, e_tag, e1, e2);
  endfunction

  task automatic drive(input vec_t v);
    dispatch_valid_i     = v.dv;
    dispatch_tag_i       = v.tag;
    dispatch_pc_i        = pc_of(v.tag);
    dispatch_inst_i      = inst_of(v.tag);
    dispatch_rs1_ready_i = v.r1r;
    dispatch_rs1_value_i = v.r1v;
    dispatch_rs1_tag_i   = v.r1t;
    dispatch_rs2_ready_i = v.r2r;
    dispatch_rs2_value_i = v.r2v;
    dispatch_rs2_tag_i   = v.r2t;
    cdb_valid_i          = v.cv;
    cdb_tag_i            = v.ct;
    cdb_value_i          = v.cval;
    flush_i              = v.fl;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    bit               rdy1;
    bit               rdy2;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
  } ment_t;

  ment_t            q[$];
  bit               m_req;
  logic [31:0]      m_pc, m_inst, m_v1, m_v2;
  logic [TAG_W-1:0] m_tag;

  // One clock of the station: oldest ready instruction leaves, the CDB wakes
  // the rest, and an accepted dispatch joins at the back.
  task automatic model_step();
    int    sel;
    bit    acc;
    bit    ok1, ok2;
    ment_t e;
    sel = -1;
    acc = (q.size() < DEPTH);
    if (flush_i) begin
      q.delete();
      m_req = 1'b0;
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        ok1 = q[i].rdy1 || (BYP && cdb_valid_i && q[i].t1 == cdb_tag_i);
        ok2 = q[i].rdy2 || (BYP && cdb_valid_i && q[i].t2 == cdb_tag_i);
        if (sel < 0 && ok1 && ok2) sel = i;
      end
      if (sel >= 0) begin
        m_req  = 1'b1;
        m_pc   = q[sel].pc;
        m_inst = q[sel].inst;
        m_tag  = q[sel].tag;
        m_v1   = q[sel].rdy1 ? q[sel].v1 : cdb_value_i;
        m_v2   = q[sel].rdy2 ? q[sel].v2 : cdb_value_i;
        q.delete(sel);
      end else begin
        m_req = 1'b0;
      end
      for (int i = 0; i < q.size(); i++) begin
        if (cdb_valid_i && !q[i].rdy1 && q[i].t1 == cdb_tag_i) begin
          q[i].rdy1 = 1'b1; q[i].v1 = cdb_value_i;
        end
        if (cdb_valid_i && !q[i].rdy2 && q[i].t2 == cdb_tag_i) begin
          q[i].rdy2 = 1'b1; q[i].v2 = cdb_value_i;
        end
      end
      if (dispatch_valid_i && acc) begin
        e.pc = dispatch_pc_i; e.inst = dispatch_inst_i; e.tag = dispatch_tag_i;
        e.t1 = dispatch_rs1_tag_i; e.t2 = dispatch_rs2_tag_i;
        e.rdy1 = dispatch_rs1_ready_i; e.v1 = dispatch_rs1_value_i;
        e.rdy2 = dispatch_rs2_ready_i; e.v2 = dispatch_rs2_value_i;
        if (!e.rdy1 && cdb_valid_i && e.t1 == cdb_tag_i) begin e.rdy1 = 1'b1; e.v1 = cdb_value_i; end
        if (!e.rdy2 && cdb_valid_i && e.t2 == cdb_tag_i) begin e.rdy2 = 1'b1; e.v2 = cdb_value_i; end
        q.push_back(e);
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    // Latency with ready operands, CDB wakeup, full queue with two-entry
    // wakeup, dispatch-cycle bypass, then flush with a concurrent dispatch.
    tbl.push_back(row(1, 1, 1, 5, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 1, 5, 3));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, 1, 'h20, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h10, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 2, 'h20, 'h10));
    tbl.push_back(row(1, 3, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 4, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(row(1, 5, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(row(1, 6, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
    tbl.push_back(row(1, 15, 1, 1, 0, 1, 1, 0, 1, 8, 'h55, 0, 0, 4, 0, 0, 0, 0));
    tbl.push_back(idle(0, 3, 1, 3, 'h55, 0));
    tbl.push_back(idle(1, 2, 1, 5, 'h55, 0));
    tbl.push_back(idle(1, 2, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h66, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 4, 'h66, 0));
    tbl.push_back(idle(1, 0, 1, 6, 'h66, 0));
    tbl.push_back(row(1, 12, 0, 0, 3, 1, 2, 0, 1, 3, 'hAB, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 12, 'hAB, 2));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, 7, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(row(1, 8, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(row(1, 9, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(row(1, 10, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 'h77, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0, 0, 0));

    reset_i = 1'b1;
    drive(idle(0, 0, 0, 0, 0, 0));
    #12;
    chk("reset_count", 32'(count_o), 0);
    chk("reset_req", 32'(alu_request_o), 0);
    chk("reset_dready", 32'(dispatch_ready_o), 1);
    chk("reset_pc", alu_pc_o, 0);
    @(negedge clk);
    reset_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_dready", i), 32'(dispatch_ready_o), 32'(tbl[i].e_dr));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_count", i), 32'(count_o), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d_req", i), 32'(alu_request_o), 32'(tbl[i].e_req));
      if (tbl[i].e_req) begin
        chk($sformatf("row%0d_tag", i), 32'(alu_tag_o), 32'(tbl[i].e_tag));
        chk($sformatf("row%0d_rs1", i), alu_rs1_value_o, tbl[i].e1);
        chk($sformatf("row%0d_rs2", i), alu_rs2_value_o, tbl[i].e2);
        chk($sformatf("row%0d_pc", i), alu_pc_o, pc_of(tbl[i].e_tag));
        chk($sformatf("row%0d_inst", i), alu_inst_o, inst_of(tbl[i].e_tag));
      end
    end

    // Asynchronous reset while an issue is being presented.
    drive(row(1, 11, 1, 'h11, 0, 1, 'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(idle(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre_reset_req", 32'(alu_request_o), 1);
    #3;
    reset_i = 1'b1;
    #1;
    chk("async_req", 32'(alu_request_o), 0);
    chk("async_count", 32'(count_o), 0);
    chk("async_dready", 32'(dispatch_ready_o), 1);
    chk("async_pc", alu_pc_o, 0);
    chk("async_inst", alu_inst_o, 0);
    chk("async_rs1", alu_rs1_value_o, 0);
    chk("async_rs2", alu_rs2_value_o, 0);
    chk("async_tag", 32'(alu_tag_o), 0);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_count", 32'(count_o), 0);
    chk("post_reset_req", 32'(alu_request_o), 0);

    // Random traffic against the queue model.
    q.delete();
    m_req = 1'b0; m_pc = '0; m_inst = '0; m_v1 = '0; m_v2 = '0; m_tag = '0;
    for (int n = 0; n < 3000; n++) begin
      dispatch_valid_i     = ($urandom_range(0, 9) < 6);
      dispatch_tag_i       = TAG_W'($urandom_range(0, 15));
      dispatch_pc_i        = $urandom;
      dispatch_inst_i      = $urandom;
      dispatch_rs1_ready_i = 1'($urandom_range(0, 1));
      dispatch_rs2_ready_i = 1'($urandom_range(0, 1));
      dispatch_rs1_value_i = $urandom;
      dispatch_rs2_value_i = $urandom;
      dispatch_rs1_tag_i   = TAG_W'($urandom_range(0, 7));
      dispatch_rs2_tag_i   = TAG_W'($urandom_range(0, 7));
      cdb_valid_i          = ($urandom_range(0, 9) < 4);
      cdb_tag_i            = TAG_W'($urandom_range(0, 7));
      cdb_value_i          = $urandom;
      flush_i              = ($urandom_range(0, 49) == 0);
      #1;
      chk("rnd_dready", 32'(dispatch_ready_o), 32'(q.size() < DEPTH));
      model_step();
      @(posedge clk);
      #1;
      chk("rnd_count", 32'(count_o), 32'(q.size()));
      chk("rnd_req", 32'(alu_request_o), 32'(m_req));
      chk("rnd_pc", alu_pc_o, m_pc);
      chk("rnd_inst", alu_inst_o, m_inst);
      chk("rnd_tag", 32'(alu_tag_o), 32'(m_tag));
      chk("rnd_rs1", alu_rs1_value_o, m_v1);
      chk("rnd_rs2", alu_rs2_value_o, m_v2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
